// File: rtl/receiver_pkg.sv
// Shared constants for the multi-channel receive stage.
package receiver_pkg;

    localparam int unsigned CH_LEFT  = 0;
    localparam int unsigned CH_RIGHT = 1;
    localparam int unsigned CH_SELF  = 2;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

endpackage

// File: rtl/channel_fifo.sv
// Per-channel circular buffer; push to a full FIFO and pop from an empty one are ignored.
module channel_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         head_c_o,
    output logic                     full_c_o,
    output logic                     empty_c_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Flags come from the registered count only, so a same-cycle pop never frees a slot for a push.
    assign full_c_o  = (count_q == CNT_W'(DEPTH));
    assign empty_c_o = (count_q == '0);
    assign head_c_o  = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    assign do_push = push_i && !full_c_o;
    assign do_pop  = pop_i && !empty_c_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only slots behind a valid count are ever read out.
    always_ff @(posedge clk) begin
        if (!reset && do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/receiver_fifo_arbiter.sv
// Multi-channel receive stage: per-link FIFOs, fixed or round-robin arbiter,
// and a registered valid/ready output carrying the source channel.
module receiver_fifo_arbiter
    import receiver_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NCH     = 3,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned RR_MODE = ARB_FIXED
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NCH-1:0]           in_valid,
    input  logic [NCH*WIDTH-1:0]     in_data,
    output logic [NCH-1:0]           in_ready,
    output logic [NCH-1:0]           overflow,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(NCH)-1:0]   out_src,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int unsigned SRC_W = $clog2(NCH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] head  [NCH];
    logic [CNT_W-1:0] count [NCH];
    logic [NCH-1:0]   full;
    logic [NCH-1:0]   empty;
    logic [NCH-1:0]   pop;

    logic             load;
    logic             grant_valid;
    logic [SRC_W-1:0] grant;

    logic [WIDTH-1:0] out_data_q,   out_data_d;
    logic [SRC_W-1:0] out_src_q,    out_src_d;
    logic             out_valid_q,  out_valid_d;
    logic [SRC_W-1:0] last_grant_q, last_grant_d;
    logic [NCH-1:0]   overflow_q,   overflow_d;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        channel_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push_i    (in_valid[c]),
            .pop_i     (pop[c]),
            .wdata_i   (in_data[c*WIDTH +: WIDTH]),
            .head_c_o  (head[c]),
            .full_c_o  (full[c]),
            .empty_c_o (empty[c]),
            .count_o   (count[c])
        );
        assign in_ready[c] = (count[c] != CNT_W'(DEPTH));
    end

    // Grant the first non-empty channel, scanning from 0 (fixed) or from last_grant+1 (round-robin).
    always_comb begin
        int unsigned start;
        int unsigned idx;
        grant_valid = 1'b0;
        grant       = '0;
        start       = 0;
        idx         = 0;
        if (RR_MODE == ARB_RR) start = (32'(last_grant_q) + 1) % NCH;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = (start + i) % NCH;
            if (!grant_valid && !empty[SRC_W'(idx)]) begin
                grant_valid = 1'b1;
                grant       = SRC_W'(idx);
            end
        end
    end

    assign load = !out_valid_q || out_ready;

    always_comb begin
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        pop          = '0;
        overflow_d   = overflow_q | (in_valid & full);
        if (load) begin
            if (grant_valid) begin
                pop[grant]   = 1'b1;
                out_data_d   = head[grant];
                out_src_d    = grant;
                out_valid_d  = 1'b1;
                last_grant_d = grant;
            end else begin
                out_valid_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q   <= '0;
            out_src_q    <= '0;
            out_valid_q  <= 1'b0;
            last_grant_q <= SRC_W'(NCH - 1);
            overflow_q   <= '0;
        end else begin
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
            overflow_q   <= overflow_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_receiver_fifo_arbiter.sv
// Directed bench: fixed-priority and round-robin instances share one stimulus stream.
module tb_receiver_fifo_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NCH   = 3;
    localparam int unsigned DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic                 out_ready;

    logic [NCH-1:0]   f_in_ready, f_overflow, r_in_ready, r_overflow;
    logic [WIDTH-1:0] f_out_data, r_out_data;
    logic [1:0]       f_out_src, r_out_src;
    logic             f_out_valid, r_out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    receiver_fifo_arbiter #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .RR_MODE(0)) u_fix (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(f_in_ready), .overflow(f_overflow), .out_data(f_out_data),
        .out_src(f_out_src), .out_valid(f_out_valid), .out_ready(out_ready)
    );

    receiver_fifo_arbiter #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .RR_MODE(1)) u_rr (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(r_in_ready), .overflow(r_overflow), .out_data(r_out_data),
        .out_src(r_out_src), .out_valid(r_out_valid), .out_ready(out_ready)
    );

    typedef struct {
        logic        rst;
        logic [2:0]  v;
        logic [31:0] d0, d1, d2;
        logic        rdy;
        logic        e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_src;
        logic [2:0]  e_ir;
        logic [2:0]  e_of;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Drive inputs, take one rising edge, then settle before sampling.
    task automatic step(input logic rst, input logic [2:0] v, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [31:0] d2, input logic rdy);
        reset     = rst;
        in_valid  = v;
        in_data   = {d2, d1, d0};
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]  rr_src [7];
        logic [31:0] rr_dat [7];
        logic [1:0]  fx_src [7];
        logic [31:0] fx_dat [7];

        reset = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b1;

        //          rst v       d0     d1            d2    rdy ov od            src ir      of
        tbl[0]  = '{1, 3'b000, 0,     0,            0,    1,  0, 0,            0, 3'b111, 3'b000};
        tbl[1]  = '{0, 3'b010, 0,     32'hA5A50001, 0,    1,  0, 0,            0, 3'b111, 3'b000};
        tbl[2]  = '{0, 3'b000, 0,     0,            0,    1,  1, 32'hA5A50001, 1, 3'b111, 3'b000};
        tbl[3]  = '{0, 3'b000, 0,     0,            0,    1,  0, 32'hA5A50001, 1, 3'b111, 3'b000};
        tbl[4]  = '{0, 3'b111, 32'h10, 32'h20,      32'h30, 1, 0, 32'hA5A50001, 1, 3'b111, 3'b000};
        tbl[5]  = '{0, 3'b000, 0,     0,            0,    1,  1, 32'h10,       0, 3'b111, 3'b000};
        tbl[6]  = '{0, 3'b000, 0,     0,            0,    1,  1, 32'h20,       1, 3'b111, 3'b000};
        tbl[7]  = '{0, 3'b000, 0,     0,            0,    1,  1, 32'h30,       2, 3'b111, 3'b000};
        tbl[8]  = '{0, 3'b000, 0,     0,            0,    1,  0, 32'h30,       2, 3'b111, 3'b000};
        tbl[9]  = '{0, 3'b010, 0,     32'hBB,       0,    0,  0, 32'h30,       2, 3'b111, 3'b000};
        tbl[10] = '{0, 3'b001, 32'h100, 0,          0,    0,  1, 32'hBB,       1, 3'b111, 3'b000};
        tbl[11] = '{0, 3'b001, 32'h101, 0,          0,    0,  1, 32'hBB,       1, 3'b111, 3'b000};
        tbl[12] = '{0, 3'b001, 32'h102, 0,          0,    0,  1, 32'hBB,       1, 3'b111, 3'b000};
        tbl[13] = '{0, 3'b001, 32'h103, 0,          0,    0,  1, 32'hBB,       1, 3'b110, 3'b000};
        tbl[14] = '{0, 3'b001, 32'h104, 0,          0,    0,  1, 32'hBB,       1, 3'b110, 3'b001};
        tbl[15] = '{0, 3'b000, 0,     0,            0,    0,  1, 32'hBB,       1, 3'b110, 3'b001};
        tbl[16] = '{0, 3'b000, 0,     0,            0,    1,  1, 32'h100,      0, 3'b111, 3'b001};
        tbl[17] = '{0, 3'b000, 0,     0,            0,    1,  1, 32'h101,      0, 3'b111, 3'b001};
        tbl[18] = '{0, 3'b000, 0,     0,            0,    1,  1, 32'h102,      0, 3'b111, 3'b001};
        tbl[19] = '{0, 3'b000, 0,     0,            0,    1,  1, 32'h103,      0, 3'b111, 3'b001};
        tbl[20] = '{0, 3'b000, 0,     0,            0,    1,  0, 32'h103,      0, 3'b111, 3'b001};

        // Fixed-priority instance: latency, simultaneous arrivals, overflow and drain.
        for (int i = 0; i < 21; i++) begin
            step(tbl[i].rst, tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].rdy);
            chk($sformatf("vec%0d out_valid", i), 32'(f_out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("vec%0d out_data", i),  f_out_data,       tbl[i].e_od);
            chk($sformatf("vec%0d out_src", i),   32'(f_out_src),   32'(tbl[i].e_src));
            chk($sformatf("vec%0d in_ready", i),  32'(f_in_ready),  32'(tbl[i].e_ir));
            chk($sformatf("vec%0d overflow", i),  32'(f_overflow),  32'(tbl[i].e_of));
        end

        // Backpressure: word held stable while out_ready is low.
        step(1, 3'b000, 0, 0, 0, 1);
        chk("bp reset overflow", 32'(f_overflow), 32'h0);
        step(0, 3'b110, 0, 32'h66, 32'h55, 0);
        chk("bp load valid", 32'(f_out_valid), 32'h0);
        step(0, 3'b000, 0, 0, 0, 0);
        chk("bp first data", f_out_data, 32'h66);
        for (int i = 0; i < 3; i++) begin
            step(0, 3'b000, 0, 0, 0, 0);
            chk($sformatf("bp hold%0d valid", i), 32'(f_out_valid), 32'h1);
            chk($sformatf("bp hold%0d data", i),  f_out_data,       32'h66);
            chk($sformatf("bp hold%0d src", i),   32'(f_out_src),   32'h1);
        end
        step(0, 3'b000, 0, 0, 0, 1);
        chk("bp next data", f_out_data, 32'h55);
        chk("bp next src",  32'(f_out_src), 32'h2);
        chk("bp next valid", 32'(f_out_valid), 32'h1);
        step(0, 3'b000, 0, 0, 0, 1);
        chk("bp drained", 32'(f_out_valid), 32'h0);

        // Round-robin vs fixed with ch0 and ch2 both loaded.
        step(1, 3'b000, 0, 0, 0, 0);
        step(0, 3'b101, 32'hC0, 0, 32'hE0, 0);
        step(0, 3'b101, 32'hC1, 0, 32'hE1, 0);
        chk("rr first src",  32'(r_out_src),  32'h0);
        chk("rr first data", r_out_data,      32'hC0);
        chk("fx first src",  32'(f_out_src),  32'h0);
        chk("fx first data", f_out_data,      32'hC0);
        step(0, 3'b101, 32'hC2, 0, 32'hE2, 0);
        step(0, 3'b101, 32'hC3, 0, 32'hE3, 0);
        rr_src = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2};
        rr_dat = '{32'hE0, 32'hC1, 32'hE1, 32'hC2, 32'hE2, 32'hC3, 32'hE3};
        fx_src = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2};
        fx_dat = '{32'hC1, 32'hC2, 32'hC3, 32'hE0, 32'hE1, 32'hE2, 32'hE3};
        for (int i = 0; i < 7; i++) begin
            step(0, 3'b000, 0, 0, 0, 1);
            chk($sformatf("rr%0d src", i),  32'(r_out_src), 32'(rr_src[i]));
            chk($sformatf("rr%0d data", i), r_out_data,     rr_dat[i]);
            chk($sformatf("fx%0d src", i),  32'(f_out_src), 32'(fx_src[i]));
            chk($sformatf("fx%0d data", i), f_out_data,     fx_dat[i]);
        end
        step(0, 3'b000, 0, 0, 0, 1);
        chk("rr drained", 32'(r_out_valid), 32'h0);
        chk("fx drained", 32'(f_out_valid), 32'h0);

        // Reset mid-operation with buffered words and a pending output.
        step(1, 3'b000, 0, 0, 0, 0);
        step(0, 3'b011, 32'h1, 32'h2, 0, 0);
        step(0, 3'b100, 0, 0, 32'h3, 0);
        chk("mid pending valid", 32'(f_out_valid), 32'h1);
        chk("mid pending data",  f_out_data,       32'h1);
        step(1, 3'b111, 32'hDEAD, 32'hBEEF, 32'hF00D, 1);
        chk("mid rst valid",    32'(f_out_valid), 32'h0);
        chk("mid rst data",     f_out_data,       32'h0);
        chk("mid rst src",      32'(f_out_src),   32'h0);
        chk("mid rst in_ready", 32'(f_in_ready),  32'h7);
        chk("mid rst overflow", 32'(f_overflow),  32'h0);
        chk("mid rst rr valid", 32'(r_out_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(0, 3'b000, 0, 0, 0, 1);
            chk($sformatf("post rst%0d fx valid", i), 32'(f_out_valid), 32'h0);
            chk($sformatf("post rst%0d rr valid", i), 32'(r_out_valid), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/receiver_fifo_arbiter.md
# receiver_fifo_arbiter

Parametrised multi-channel receive stage for a network node. It buffers words arriving on NCH independent input links in per-channel FIFOs and arbitrates among them. The winner goes to a single registered output with a valid/ready handshake and a source tag. It sits between the node's link inputs (left, right, self) and the routing controller. Unlike a single-register receiver, it does not lose back-to-back words and does not starve the lower-priority channels when round-robin mode is on.

## Interface
Parameters:
- WIDTH, 32, data word width
- NCH, 3, number of input channels (≥2); default ordering 0=left, 1=right, 2=self
- DEPTH, 4, entries per channel FIFO (power of two, ≥2)
- RR_MODE, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous active-high reset
- in_valid  in  NCH  per-channel write strobe, one word per cycle per channel
- in_data  in  NCH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- in_ready  out  NCH  channel FIFO not full (informational; links do not stall)
- overflow  out  NCH  sticky: a write arrived while that FIFO was full
- out_data  out  WIDTH  selected word (registered)
- out_src  out  $clog2(NCH)  channel index of out_data
- out_valid  out  1  out_data/out_src hold an unconsumed word
- out_ready  in  1  consumer accepts the word this cycle

## Operation
- Push: the word is written when in_valid[c] && in_ready[c]. When the FIFO is full, the word is dropped and overflow[c] is set. A same-cycle pop does not rescue a write to a full FIFO.
- in_ready[c] = !full[c], computed from registered count only.
- Output register load enable: load = !out_valid || out_ready.
- When load is high and at least one FIFO is non-empty:
  - pop the granted channel's head;
  - register it into out_data;
  - set out_src = granted index and out_valid = 1.
- When load is high and all FIFOs are empty: out_valid goes to 0. out_data and out_src hold their last values; the output is never driven to X or Z.
- Fixed priority (RR_MODE=0): the lowest non-empty index is granted.
- Round-robin (RR_MODE=1):
  - last_grant is a register.
  - The search starts at last_grant+1 mod NCH.
  - last_grant updates only on an actual grant.
- Per-FIFO push and pop in the same cycle: count is unchanged, and both pointers advance and wrap mod DEPTH.
- Each count is $clog2(DEPTH)+1 bits. full = (count==DEPTH); empty = (count==0).

## Timing
- Reset values: all FIFO counts and pointers 0, in_ready all 1, overflow 0, out_valid 0, out_data 0, out_src 0, last_grant NCH-1 (so channel 0 is first in RR).
- Reset asserted mid-operation discards all buffered words and the output word on that edge. Inputs presented during reset are ignored.
- Latency: a word written at edge N into an empty system, with the output register free, appears with out_valid=1 after edge N+1.
- Throughput: one word per cycle out while out_ready=1 and any FIFO is non-empty.
- Handshake:
  - The transfer occurs on an edge where out_valid && out_ready.
  - out_data and out_src are stable while out_valid && !out_ready.
  - Back-to-back pops are allowed.
- Simultaneous arrivals on all channels in one cycle are all stored (one per FIFO); none are lost.

## Structure
- Package receiver_pkg:
  - channel index constants CH_LEFT=0, CH_RIGHT=1, CH_SELF=2;
  - arbitration mode constants ARB_FIXED=0, ARB_RR=1.
- Sub-module channel_fifo (WIDTH, DEPTH):
  - circular buffer with push, pop, head data, full, empty, count;
  - instantiated NCH times via generate.
- The arbiter is combinational logic plus the last_grant register, inside the top module.

## Test plan
- Reset, then one word 0xA5A5_0001 on ch1 at cycle 0 with out_ready=1 → out_valid=1 with out_data=0xA5A5_0001 and out_src=1 after edge 1, then out_valid=0.
- Fixed mode: same cycle, ch0=0x10, ch1=0x20, ch2=0x30, out_ready=1 → outputs 0x10, 0x20, 0x30 on three consecutive cycles, src 0,1,2.
- RR mode: 4 words each pre-loaded on ch0 and ch2, out_ready=1 → src sequence 0,2,0,2,0,2,0,2; fixed mode gives 0,0,0,0,2,2,2,2.
- DEPTH=4, out_ready=0: 5 writes on ch0 → in_ready[0]=0 after the 4th; 5th dropped; overflow[0]=1 sticky; drain yields exactly the first 4 words in order.
- Backpressure: out_ready low for 3 cycles with out_valid=1 → out_data/out_src unchanged. Raise out_ready → next word the following cycle.
- Reset asserted while 2 words are buffered and out_valid=1 → next cycle out_valid=0, in_ready all 1, overflow 0. No stale words emerge afterward.
